data_mem_responder: RTL

Multi-cycle data-memory responder for the CPU's data-memory port. It accepts one load or store request at a time over a req/ready handshake, inserts a parameterised number of wait states, and applies byte-lane writes to an internal word-organised array. It returns read data and an error flag for misaligned or out-of-range addresses. It sits on the responder side of the CPU's addr / wdata / 4-bit wren / rdata data path, as the slow-memory counterpart to the initiator that drives that path.

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Slow data-memory responder for the CPU data port. Accepts one load or
//   store at a time on a req/ready handshake, waits WAIT_CYCLES extra cycles,
//   then performs the access on a word-organised array with byte-lane writes.
//   Misaligned or out-of-range addresses complete with err=1 and rdata=0.
//
//   Parameters
//     DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//     WAIT_CYCLES : extra wait states per transaction (0..15)
//   Ports
//     clk   : clock, rising edge
//     rst   : synchronous active-high reset
//     req   : request valid, held by the initiator until it samples ready
//     wren  : byte-lane write enables, 0000 means read
//     addr  : byte address, must be word aligned
//     wdata : store data
//     rdata : read data / pre-write word, held until the next completion
//     ready : one-cycle completion pulse
//     busy  : transaction in flight (WAIT or DONE)
//     err   : error status of the last completion, held like rdata
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [3:0]  wren,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_latch;
   logic        w_access;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wren;
   logic [31:0] r_rdata;
   logic        r_err;

   logic             w_addr_err;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_rd_word;
   logic [31:0]      w_wr_word;

   logic [31:0] r_mem [DEPTH_WORDS];

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = 4'(WAIT_CYCLES);
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_access    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Address decode on the latched request only, so inputs may change freely
   // after the accept edge.
   always_comb begin
      w_addr_err = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= DEPTH_WORDS);
      w_idx      = r_addr[IDX_W+1:2];
      w_rd_word  = r_mem[w_idx];
      w_wr_word  = w_rd_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (r_wren[i]) begin
            w_wr_word[8*i +: 8] = r_wdata[8*i +: 8];
         end
      end
   end

   // State register and latched request / response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wren  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wren  <= wren;
         end
         if (w_access) begin
            r_rdata <= w_addr_err ? '0 : w_rd_word;
            r_err   <= w_addr_err;
         end
      end
   end

   // Array write; gated by rst so a reset at the access edge discards it.
   always_ff @(posedge clk) begin
      if (!rst && w_access && !w_addr_err && (r_wren != '0)) begin
         r_mem[w_idx] <= w_wr_word;
      end
   end

   assign rdata = r_rdata;
   assign err   = r_err;
   assign ready = (r_state == S_DONE);
   assign busy  = (r_state != S_IDLE);

endmodule
